x25519_mod_reduce: RTL and testbench
====================================

Name: x25519_mod_reduce

Overview:
Multi-cycle modular reducer for the X25519 datapath. It takes the 512-bit Karatsuba product, or the 38-folded product the multiplier emits in its reduction mode, and returns the canonical residue modulo p = 2^255-19.
It sits directly downstream of the field multiplier and is the consumer end of that multiplier's C/valid output.
Reduction uses three fold stages and one conditional subtract, sequenced by a small FSM, one stage per clock.

Parameters:
IN_WIDTH, 512, width of product input X.
ACC_WIDTH, 264, internal accumulator width; must be at least 263.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
pre_folded  input  1  1 = X was already 38-folded by the multiplier (X < 2^263), so the FOLD1 stage is skipped
X  input  IN_WIDTH  value to reduce
R  output  255  canonical residue, 0 <= R < p
valid  output  1  one-cycle pulse; R is valid in the same cycle
busy  output  1  high while an operation is in flight

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- Reset values: R=0, valid=0, busy=0, state=IDLE, acc=0. A reset mid-operation aborts the operation; no valid pulse is produced for it.
- States are IDLE, FOLD1, FOLD2, FOLD3, CSUB.
- IDLE:
  - If start=1, register X into acc and set busy=1.
  - Next state is FOLD2 if pre_folded=1, else FOLD1.
  - pre_folded is sampled only at this edge.
- FOLD1: acc <= X_lo + 38*X_hi, where X_lo = acc[255:0] and X_hi = acc[511:256]. The result is < 39*2^256, so it fits in 263 bits. Next state FOLD2.
- FOLD2: acc <= acc[254:0] + 19*acc[262:255]. The result is < 2^255 + 4845. Next state FOLD3.
- FOLD3: acc <= acc[254:0] + 19*acc[255]. The result is < 2^255 + 19, which is < 2p. Next state CSUB.
- CSUB:
  - R <= (acc >= p) ? acc - p : acc.
  - valid <= 1 for exactly one cycle; busy <= 0; next state IDLE.
- Latency, counting from the capture edge to the edge that asserts valid: 4 edges with pre_folded=0, 3 edges with pre_folded=1.
- Throughput: a new start is accepted in the cycle valid is high, since busy=0 and state=IDLE. This gives back-to-back issue every 5 cycles (4 with pre_folded).
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt the operation in flight.
- R holds its last value until the next CSUB; it is not cleared when valid drops.
- X may change after the capture edge without effect.
- Input range with pre_folded=1: X[511:263] must be zero; behaviour is undefined otherwise.
- The only required input check is an SVA assertion.
- Arithmetic is unsigned throughout and no operation may overflow ACC_WIDTH. Multiplication by 38 and by 19 is built from shifts and adds (38 = 32+4+2, 19 = 16+2+1); no DSP inference is required.

Decomposition:
- Shared package x25519_pkg:
  - P_25519 (255-bit constant).
  - FOLD_C256 = 38 and FOLD_C255 = 19.
  - State enum (IDLE, FOLD1, FOLD2, FOLD3, CSUB).
- One natural sub-module, x25519_csub: combinational conditional subtract of p, with 256-bit input and 255-bit output. It is reusable by the add/sub units.
- The fold logic stays inline and muxed on state. A single shared 263-bit adder is permitted.

Test Plan:
- Reset, then X=0, pre_folded=0, start: valid exactly 4 edges after capture, R=0, busy high for 4 cycles.
- X=p (2^255-19): R=0. X=2^255: R=19. X=p-1: R=p-1, exercising the CSUB boundary without subtracting.
- X=(p-1)^2: R=1. X=2^512-1: R=1443. Cover the all-ones full-width input.
- pre_folded=1, X=2^262-1: valid 3 edges after capture, R=2431. Then X=2^255+18: R=37.
- Timing and reset:
  - start held high continuously: a new operation begins on each cycle valid is high, and there is no extra capture while busy.
  - rst asserted in FOLD2: valid stays 0, R=0, state returns to IDLE, and the next start completes normally.
- Random regression of 10k X (mixing both modes) against a golden X mod p model. Check the latency and the single-cycle valid pulse on every transaction.

Source files
------------

// File: rtl/x25519_pkg.sv
// Shared constants and FSM encoding for the X25519 modular reduction datapath.
package x25519_pkg;

    localparam logic [254:0] P_25519 =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    // 2^256 = 38 (mod p) and 2^255 = 19 (mod p)
    localparam int FOLD_C256 = 38;
    localparam int FOLD_C255 = 19;

    typedef enum logic [2:0] {
        IDLE,
        FOLD1,
        FOLD2,
        FOLD3,
        CSUB
    } state_t;

endpackage

// File: rtl/x25519_csub.sv
// Conditional subtract of p: maps any a < 2p onto its canonical residue.
module x25519_csub
    import x25519_pkg::*;
(
    input  logic [255:0] a,
    output logic [254:0] r
);

    logic [254:0] diff;

    // a < 2p, so a - p < 2^255 and a 255-bit wrap-around subtraction is exact
    assign diff = a[254:0] - P_25519;
    assign r    = (a >= {1'b0, P_25519}) ? diff : a[254:0];

endmodule

// File: rtl/x25519_mod_reduce.sv
// Multi-cycle reduction of a 512-bit (or pre-folded 263-bit) product mod 2^255-19.
//
// state | meaning
// IDLE  | waiting for start; captures X
// FOLD1 | acc = acc[255:0] + 38*acc[511:256]
// FOLD2 | acc = acc[254:0] + 19*acc[262:255]
// FOLD3 | acc = acc[254:0] + 19*acc[255]
// CSUB  | R = acc mod p, pulse valid
module x25519_mod_reduce
    import x25519_pkg::*;
#(
    parameter int IN_WIDTH  = 512,
    parameter int ACC_WIDTH = 264
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pre_folded,
    input  logic [IN_WIDTH-1:0] X,
    output logic [254:0]        R,
    output logic                valid,
    output logic                busy
);

    state_t                state;
    logic [IN_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]  add_a;
    logic [ACC_WIDTH-1:0]  add_b;
    logic [ACC_WIDTH-1:0]  sum;
    logic [254:0]          csub_r;

    function automatic logic [ACC_WIDTH-1:0] mul38(input logic [255:0] h);
        logic [ACC_WIDTH-1:0] e;
        e = ACC_WIDTH'(h);
        return (e << 5) + (e << 2) + (e << 1);
    endfunction

    function automatic logic [ACC_WIDTH-1:0] mul19(input logic [7:0] h);
        logic [ACC_WIDTH-1:0] e;
        e = ACC_WIDTH'(h);
        return (e << 4) + (e << 1) + e;
    endfunction

    // acc holds the full product only until FOLD1; afterwards only the low
    // ACC_WIDTH bits are live and one adder serves every fold stage
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            FOLD1: begin
                add_a = ACC_WIDTH'(acc[255:0]);
                add_b = mul38(acc[511:256]);
            end
            FOLD2: begin
                add_a = ACC_WIDTH'(acc[254:0]);
                add_b = mul19(acc[262:255]);
            end
            FOLD3: begin
                add_a = ACC_WIDTH'(acc[254:0]);
                add_b = mul19({7'd0, acc[255]});
            end
            default: ;
        endcase
    end

    assign sum = add_a + add_b;

    x25519_csub u_csub (
        .a (acc[255:0]),
        .r (csub_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            R     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= X;
                        busy  <= 1'b1;
                        state <= pre_folded ? FOLD2 : FOLD1;
                    end
                end
                FOLD1: begin
                    acc   <= IN_WIDTH'(sum);
                    state <= FOLD2;
                end
                FOLD2: begin
                    acc   <= IN_WIDTH'(sum);
                    state <= FOLD3;
                end
                FOLD3: begin
                    acc   <= IN_WIDTH'(sum);
                    state <= CSUB;
                end
                CSUB: begin
                    R     <= csub_r;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_prefold_range: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE && start && pre_folded) |-> (X[IN_WIDTH-1:263] == '0));

endmodule

// File: tb/tb_x25519_mod_reduce.sv
// Directed and randomized checks of x25519_mod_reduce against X mod p.
module tb_x25519_mod_reduce;
    import x25519_pkg::*;

    logic         clk;
    logic         rst;
    logic         start;
    logic         pre_folded;
    logic [511:0] X;
    logic [254:0] R;
    logic         valid;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    x25519_mod_reduce dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pre_folded (pre_folded),
        .X          (X),
        .R          (R),
        .valid      (valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [254:0] ref_mod(input logic [511:0] x);
        logic [511:0] pw;
        logic [511:0] r;
        pw = {257'd0, P_25519};
        r  = x % pw;
        return r[254:0];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called 1 time unit after a posedge with the DUT idle; returns there too.
    task automatic do_op(input logic [511:0] x, input logic pf,
                         input logic [254:0] exp, input string tag);
        int lat;
        int exp_lat;
        exp_lat = pf ? 3 : 4;
        start = 1'b1; X = x; pre_folded = pf;
        @(posedge clk); #1;
        start = 1'b0;
        X = rand512();
        pre_folded = ~pf;
        lat = 0;
        while (!valid && lat < 10) begin
            chk({tag, "_busy"}, 512'(busy), 512'(1));
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 512'(lat), 512'(exp_lat));
        chk({tag, "_R"}, 512'(R), 512'(exp));
        chk({tag, "_busy_done"}, 512'(busy), 512'(0));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 512'(valid), 512'(0));
        chk({tag, "_hold"}, 512'(R), 512'(exp));
    endtask

    initial begin
        logic [511:0] pm1;
        logic [511:0] x1;
        logic [511:0] x2;
        logic [511:0] xr;
        logic         pf;
        int           n;

        rst = 1'b1; start = 1'b0; pre_folded = 1'b0; X = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_R", 512'(R), 512'(0));
        chk("rst_valid", 512'(valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(512'd0, 1'b0, 255'd0, "zero");
        do_op({257'd0, P_25519}, 1'b0, 255'd0, "x_p");
        do_op(512'd1 << 255, 1'b0, 255'd19, "x_2p255");
        do_op({257'd0, P_25519} - 512'd1, 1'b0, P_25519 - 255'd1, "x_pm1");
        pm1 = {257'd0, P_25519} - 512'd1;
        do_op(pm1 * pm1, 1'b0, 255'd1, "x_pm1_sq");
        do_op({512{1'b1}}, 1'b0, 255'd1443, "all_ones");
        do_op((512'd1 << 262) - 512'd1, 1'b1, 255'd2431, "pf_max");
        do_op((512'd1 << 255) + 512'd18, 1'b1, 255'd37, "pf_2p255_18");

        // start held high: the next capture happens only on the valid cycle
        x1 = rand512();
        x2 = rand512();
        start = 1'b1; pre_folded = 1'b0; X = x1;
        @(posedge clk); #1;
        X = x2;
        n = 0;
        while (!valid && n < 10) begin
            chk("b2b_busy1", 512'(busy), 512'(1));
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_lat1", 512'(n), 512'(4));
        chk("b2b_R1", 512'(R), 512'(ref_mod(x1)));
        chk("b2b_idle", 512'(busy), 512'(0));
        @(posedge clk); #1;
        X = rand512();
        chk("b2b_recapture", 512'(busy), 512'(1));
        n = 1;
        while (!valid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("b2b_interval", 512'(n), 512'(5));
        chk("b2b_R2", 512'(R), 512'(ref_mod(x2)));
        @(posedge clk); #1;
        chk("b2b_stop", 512'(busy), 512'(0));
        chk("b2b_pulse", 512'(valid), 512'(0));

        // reset while in FOLD2 aborts without a valid pulse
        start = 1'b1; pre_folded = 1'b0; X = rand512();
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_fold2", 512'(dut.state), 512'(FOLD2));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_R", 512'(R), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_state", 512'(dut.state), 512'(IDLE));
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid) n++;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", 512'(n), 512'(0));
        xr = rand512();
        do_op(xr, 1'b0, ref_mod(xr), "after_abort");

        for (int i = 0; i < 10000; i++) begin
            pf = 1'($urandom_range(0, 1));
            xr = rand512();
            case ($urandom_range(0, 7))
                0: xr[511:480] = '1;
                1: xr[254:0] = P_25519 - 255'($urandom_range(0, 40));
                default: ;
            endcase
            if (pf) begin
                xr[511:263] = '0;
                if ($urandom_range(0, 3) == 0) xr[262:240] = '1;
            end
            do_op(xr, pf, ref_mod(xr), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
